// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and defaults for the round-robin arbiter
package arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;

  localparam int ARB_N        = 4;
  localparam int ARB_MAX_HOLD = 16;

  // Explicit wrap so N need not be a power of two.
  function automatic int next_idx(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_ctrl_if.sv
// rtl/rr_arbiter_ctrl_if.sv - request/grant bundle between requesters and the arbiter
interface rr_arbiter_ctrl_if
  import arb_pkg::*;
#(
  parameter int N = ARB_N
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic          timeout;

  modport master (output req, input gnt, gnt_id, busy, timeout);
  modport slave  (input req, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first set request bit at or after ptr, wrapping modulo N
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan downward so the candidate closest to ptr is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_ctrl.sv
// rtl/rr_arbiter_ctrl.sv - hold-based round-robin arbiter with maximum-tenure preemption
module rr_arbiter_ctrl
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  rr_arbiter_ctrl_if.slave  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD);

  arb_state_t    r_state;
  logic [N-1:0]  r_gnt;
  logic [IW-1:0] r_gnt_id;
  logic [IW-1:0] r_ptr;
  logic [HW-1:0] r_hold;
  logic          r_busy;
  logic          r_timeout;

  logic          w_found;
  logic [IW-1:0] w_idx;
  logic          w_arb;
  logic          w_expire;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (bus.req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  // Release is tested before expiry, so a drop on the last tenure cycle never preempts.
  assign w_arb    = (r_state != GRANT) || !bus.req[r_gnt_id];
  assign w_expire = (r_hold == HW'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (w_arb && w_found) begin
        r_state  <= GRANT;
        r_gnt    <= N'(1) << w_idx;
        r_gnt_id <= w_idx;
        r_ptr    <= IW'(next_idx(int'(w_idx), N));
        r_hold   <= '0;
        r_busy   <= 1'b1;
      end else if (w_arb) begin
        r_state <= IDLE;
        r_gnt   <= '0;
        r_busy  <= 1'b0;
      end else if (w_expire) begin
        r_state   <= GAP;
        r_gnt     <= '0;
        r_busy    <= 1'b0;
        r_timeout <= 1'b1;
      end else begin
        r_hold <= r_hold + HW'(1);
      end
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// tb/tb_rr_arbiter_ctrl.sv - directed table, corner sequences and randomized model check
module tb_rr_arbiter_ctrl;

  localparam int N  = 4;
  localparam int MH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arbiter_ctrl_if #(.N(N)) bus ();

  rr_arbiter_ctrl #(.N(N), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: who holds the resource, for how long, and where priority starts.
  int m_holder;
  int m_last;
  int m_ptr;
  int m_hold;
  bit m_to;

  function automatic int m_pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic m_reset();
    m_holder = -1; m_last = 0; m_ptr = 0; m_hold = 0; m_to = 0;
  endtask

  task automatic m_edge(input logic [N-1:0] r);
    int w;
    m_to = 0;
    if (m_holder >= 0 && r[m_holder] && m_hold == MH - 1) begin
      m_holder = -1;
      m_to = 1;
    end else if (m_holder >= 0 && r[m_holder]) begin
      m_hold++;
    end else begin
      w = m_pick(r);
      m_holder = w;
      if (w >= 0) begin
        m_last = w; m_ptr = (w + 1) % N; m_hold = 0;
      end
    end
  endtask

  function automatic logic [N-1:0] m_gnt();
    return (m_holder >= 0) ? (N'(1) << m_holder) : '0;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] r);
    bus.req = r;
    @(posedge clk);
    m_edge(r);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_id", 32'(bus.gnt_id), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_to", 32'(bus.timeout), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_reset();
  endtask

  typedef struct {
    bit       do_rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic     busy;
    logic     to;
  } vec_t;

  vec_t tbl[$];
  logic [N-1:0] r;

  initial begin
    rst = 1'b1;
    bus.req = '0;
    m_reset();

    tbl.push_back('{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1, 1'b0});

    #1;
    foreach (tbl[i]) begin
      if (tbl[i].do_rst) do_reset();
      step(tbl[i].req);
      check($sformatf("tbl%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_id", i), 32'(bus.gnt_id), 32'(tbl[i].id));
      check($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      check($sformatf("tbl%0d_to", i), 32'(bus.timeout), 32'(tbl[i].to));
    end

    // Lone holder: 16 granted cycles, one GAP with timeout, then regrant.
    do_reset();
    for (int i = 1; i <= MH; i++) begin
      step(4'b0001);
      check($sformatf("tmo_hold%0d", i), 32'(bus.gnt), 32'h1);
      check("tmo_hold_to", 32'(bus.timeout), 0);
    end
    step(4'b0001);
    check("tmo_gap_gnt", 32'(bus.gnt), 0);
    check("tmo_gap_to", 32'(bus.timeout), 1);
    check("tmo_gap_busy", 32'(bus.busy), 0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0001);
      check("tmo_regrant", 32'(bus.gnt), 32'h1);
      check("tmo_regrant_to", 32'(bus.timeout), 0);
    end

    // Preempted holder drops to lowest priority behind a later requester.
    do_reset();
    for (int i = 1; i <= MH; i++) begin
      step((i >= 4) ? 4'b1010 : 4'b0010);
      check("pre_hold", 32'(bus.gnt), 32'h2);
    end
    step(4'b1010);
    check("pre_gap_gnt", 32'(bus.gnt), 0);
    check("pre_gap_to", 32'(bus.timeout), 1);
    step(4'b1010);
    check("pre_next_gnt", 32'(bus.gnt), 32'h8);
    check("pre_next_id", 32'(bus.gnt_id), 3);

    // Release on the expiry edge wins over the timeout.
    do_reset();
    for (int i = 1; i <= MH; i++) begin
      step(4'b0101);
      check("rel_hold", 32'(bus.gnt), 32'h1);
    end
    step(4'b0100);
    check("rel_edge_to", 32'(bus.timeout), 0);
    check("rel_edge_gnt", 32'(bus.gnt), 32'h4);

    // Reset mid-tenure clears outputs at once and restores ptr to 0.
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b0100);
    check("mid_pre_gnt", 32'(bus.gnt), 32'h4);
    do_reset();
    step(4'b1010);
    check("mid_post_gnt", 32'(bus.gnt), 32'h2);
    check("mid_post_id", 32'(bus.gnt_id), 1);

    // Randomized traffic against the reference.
    do_reset();
    r = '0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
      step(r);
      check($sformatf("rnd%0d_gnt", c), 32'(bus.gnt), 32'(m_gnt()));
      check($sformatf("rnd%0d_id", c), 32'(bus.gnt_id), 32'(m_last));
      check($sformatf("rnd%0d_busy", c), 32'(bus.busy), 32'(m_holder >= 0));
      check($sformatf("rnd%0d_to", c), 32'(bus.timeout), 32'(m_to));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
